// File: rtl/ppu_frame_seq.sv
// ppu_frame_seq: parametrised PPU frame sequencer.
// Walks the screen line by line and tile group by tile group. It drives the
// colour-load, sprite-evaluation and tile-render engines through start/busy
// handshakes. It latches scroll state at frame and line boundaries, raises
// vblank/NMI, and keeps a sticky handshake watchdog and a frame counter.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   vga_done                      frame buffer released, a frame may start
//   ppu_ctrl1                     [7] NMI enable, [1:0] nametable select
//   ppu_ctrl2                     [3] background enable, [4] sprite enable
//   cpu_scroll_addr               {scroll X, scroll Y}
//   status_rd                     CPU status read pulse (clears vblank)
//   color/sprite/tile _start/_busy  engine handshakes
//   pixel_row, pixel_col          current row / first column of the group (signed)
//   scroll_latch, nt_latch        latched scroll and nametable select
//   vblank, nmi                   status bit 7, vblank & NMI enable
//   hs_timeout                    sticky watchdog error
//   frame_cnt                     completed frames (wraps)
module ppu_frame_seq #(
  parameter int SCREEN_W      = 256,
  parameter int SCREEN_H      = 240,
  parameter int TILE_W        = 8,
  parameter int COL_W         = 9,
  parameter int ROW_W         = 9,
  parameter int HBLANK_CYCLES = 100,
  parameter int START_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vga_done,
  input  logic [7:0]       ppu_ctrl1,
  input  logic [7:0]       ppu_ctrl2,
  input  logic [15:0]      cpu_scroll_addr,
  input  logic             status_rd,
  output logic             color_start,
  input  logic             color_busy,
  output logic             sprite_start,
  input  logic             sprite_busy,
  output logic             tile_start,
  input  logic             tile_busy,
  output logic [ROW_W-1:0] pixel_row,
  output logic [COL_W-1:0] pixel_col,
  output logic [15:0]      scroll_latch,
  output logic [1:0]       nt_latch,
  output logic             vblank,
  output logic             nmi,
  output logic             hs_timeout,
  output logic [7:0]       frame_cnt
);

  localparam int WD_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int HB_W = (HBLANK_CYCLES > 1) ? $clog2(HBLANK_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, COLOR_REQ, COLOR_WAIT, SPR_REQ, SPR_WAIT,
    TILE_REQ, TILE_WAIT, HBLANK, VBLANK_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [15:0]      scroll_q, scroll_d;
  logic [1:0]       nt_q, nt_d;
  logic             vblank_q, vblank_d;
  logic             hs_q, hs_d;
  logic [7:0]       frame_q, frame_d;
  logic             color_start_q, color_start_d;
  logic             sprite_start_q, sprite_start_d;
  logic             tile_start_q, tile_start_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [HB_W-1:0]  hb_q, hb_d;

  logic [COL_W-1:0] neg_fine;
  logic [COL_W:0]   col_ext, col_adv;
  logic             line_full, wd_expired, render_en, last_row;
  logic             go_spr, spr_done, tile_done, go_tile, eol, vblank_set, frame_begin;
  logic             unused_ctrl;

  // First group of a line starts fine-X pixels left of the screen edge.
  assign neg_fine   = '0 - {{(COL_W-3){1'b0}}, cpu_scroll_addr[10:8]};
  // One extra bit so the column + TILE_W compare cannot overflow.
  assign col_ext    = {col_q[COL_W-1], col_q};
  assign col_adv    = col_ext + (COL_W+1)'(TILE_W);
  assign line_full  = $signed(col_adv) >= $signed((COL_W+1)'(SCREEN_W));
  assign wd_expired = (wd_q == WD_W'(START_TIMEOUT - 1));
  assign render_en  = ppu_ctrl2[3] | ppu_ctrl2[4];
  assign last_row   = (row_q == ROW_W'(SCREEN_H - 1));
  assign unused_ctrl = ^{ppu_ctrl1[6:2], ppu_ctrl2[7:5], ppu_ctrl2[2:0]};

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    scroll_d       = scroll_q;
    nt_d           = nt_q;
    vblank_d       = vblank_q;
    hs_d           = hs_q;
    frame_d        = frame_q;
    color_start_d  = color_start_q;
    sprite_start_d = sprite_start_q;
    tile_start_d   = tile_start_q;
    wd_d           = wd_q;
    hb_d           = hb_q;
    go_spr         = 1'b0;
    spr_done       = 1'b0;
    tile_done      = 1'b0;
    go_tile        = 1'b0;
    eol            = 1'b0;
    vblank_set     = 1'b0;
    frame_begin    = 1'b0;

    // A watchdog expiry in *_REQ is treated exactly like the matching *_WAIT
    // completion, so both paths funnel into the shared done flags below.
    case (state_q)
      IDLE: if (vga_done) begin
        frame_begin   = 1'b1;
        row_d         = '0;
        scroll_d      = cpu_scroll_addr;
        nt_d          = ppu_ctrl1[1:0];
        col_d         = neg_fine;
        color_start_d = 1'b1;
        wd_d          = '0;
        state_d       = COLOR_REQ;
      end
      COLOR_REQ: begin
        if (color_busy) begin
          color_start_d = 1'b0;
          state_d       = COLOR_WAIT;
        end else if (wd_expired) begin
          hs_d          = 1'b1;
          color_start_d = 1'b0;
          go_spr        = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      COLOR_WAIT: if (!color_busy) go_spr = 1'b1;
      SPR_REQ: begin
        if (sprite_busy) begin
          sprite_start_d = 1'b0;
          state_d        = SPR_WAIT;
        end else if (wd_expired) begin
          hs_d           = 1'b1;
          sprite_start_d = 1'b0;
          spr_done       = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      SPR_WAIT: if (!sprite_busy) spr_done = 1'b1;
      TILE_REQ: begin
        if (tile_busy) begin
          tile_start_d = 1'b0;
          state_d      = TILE_WAIT;
        end else if (wd_expired) begin
          hs_d         = 1'b1;
          tile_start_d = 1'b0;
          tile_done    = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      TILE_WAIT: if (!tile_busy) tile_done = 1'b1;
      HBLANK: begin
        if (hb_q == HB_W'(HBLANK_CYCLES - 1)) go_spr = 1'b1;
        else hb_d = hb_q + 1'b1;
      end
      VBLANK_WAIT: if (!vga_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (spr_done) begin
      if (render_en) go_tile = 1'b1;
      else eol = 1'b1;
    end
    if (tile_done) begin
      if (line_full) begin
        eol = 1'b1;
      end else begin
        col_d   = col_adv[COL_W-1:0];
        go_tile = 1'b1;
      end
    end
    if (go_spr) begin
      sprite_start_d = 1'b1;
      wd_d           = '0;
      state_d        = SPR_REQ;
    end
    if (go_tile) begin
      tile_start_d = 1'b1;
      wd_d         = '0;
      state_d      = TILE_REQ;
    end
    if (eol) begin
      if (last_row) begin
        vblank_set = 1'b1;
        frame_d    = frame_q + 8'd1;
        state_d    = VBLANK_WAIT;
      end else begin
        row_d          = row_q + 1'b1;
        scroll_d[15:8] = cpu_scroll_addr[15:8];
        nt_d[0]        = ppu_ctrl1[0];
        col_d          = neg_fine;
        hb_d           = '0;
        state_d        = HBLANK;
      end
    end

    // Setting vblank takes priority over a coincident status read.
    if (vblank_set) vblank_d = 1'b1;
    else if (status_rd || frame_begin) vblank_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      row_q          <= '0;
      col_q          <= '0;
      scroll_q       <= '0;
      nt_q           <= '0;
      vblank_q       <= 1'b0;
      hs_q           <= 1'b0;
      frame_q        <= '0;
      color_start_q  <= 1'b0;
      sprite_start_q <= 1'b0;
      tile_start_q   <= 1'b0;
      wd_q           <= '0;
      hb_q           <= '0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_q          <= col_d;
      scroll_q       <= scroll_d;
      nt_q           <= nt_d;
      vblank_q       <= vblank_d;
      hs_q           <= hs_d;
      frame_q        <= frame_d;
      color_start_q  <= color_start_d;
      sprite_start_q <= sprite_start_d;
      tile_start_q   <= tile_start_d;
      wd_q           <= wd_d;
      hb_q           <= hb_d;
    end
  end

  assign color_start  = color_start_q;
  assign sprite_start = sprite_start_q;
  assign tile_start   = tile_start_q;
  assign pixel_row    = row_q;
  assign pixel_col    = col_q;
  assign scroll_latch = scroll_q;
  assign nt_latch     = nt_q;
  assign vblank       = vblank_q;
  assign nmi          = vblank_q & ppu_ctrl1[7];
  assign hs_timeout   = hs_q;
  assign frame_cnt    = frame_q;

endmodule

// File: tb/tb_ppu_frame_seq.sv
// Bench for ppu_frame_seq: a per-frame list of expected engine requests
// (engine, row, column, latched scroll, nametable) is built from the
// screen/scroll rules and consumed as the DUT raises its start signals.
module tb_ppu_frame_seq;
  localparam int SW  = 256;
  localparam int SH  = 8;
  localparam int TW  = 8;
  localparam int HB  = 20;
  localparam int STO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vga_done = 1'b0;
  logic [7:0]  ppu_ctrl1 = 8'h00;
  logic [7:0]  ppu_ctrl2 = 8'h18;
  logic [15:0] cpu_scroll_addr = 16'h0000;
  logic        status_rd = 1'b0;
  logic [2:0]  bz = 3'b000;
  logic        color_start, sprite_start, tile_start;
  logic [8:0]  pixel_row, pixel_col;
  logic [15:0] scroll_latch;
  logic [1:0]  nt_latch;
  logic        vblank, nmi, hs_timeout;
  logic [7:0]  frame_cnt;
  logic [2:0]  st_now;

  ppu_frame_seq #(
    .SCREEN_W(SW), .SCREEN_H(SH), .TILE_W(TW), .COL_W(9), .ROW_W(9),
    .HBLANK_CYCLES(HB), .START_TIMEOUT(STO)
  ) dut (
    .clk(clk), .rst(rst), .vga_done(vga_done), .ppu_ctrl1(ppu_ctrl1),
    .ppu_ctrl2(ppu_ctrl2), .cpu_scroll_addr(cpu_scroll_addr), .status_rd(status_rd),
    .color_start(color_start), .color_busy(bz[0]),
    .sprite_start(sprite_start), .sprite_busy(bz[1]),
    .tile_start(tile_start), .tile_busy(bz[2]),
    .pixel_row(pixel_row), .pixel_col(pixel_col), .scroll_latch(scroll_latch),
    .nt_latch(nt_latch), .vblank(vblank), .nmi(nmi), .hs_timeout(hs_timeout),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  assign st_now = {tile_start, sprite_start, color_start};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- expected request model ----------------
  typedef struct { int eng; int row; int col; int latch; int nt; } ev_t;
  ev_t exp_q[$];

  task automatic push_ev(input int e, input int r, input int c, input int l, input int n);
    ev_t ev;
    ev.eng = e; ev.row = r; ev.col = c; ev.latch = l; ev.nt = n;
    exp_q.push_back(ev);
  endtask

  // x0: scroll X at frame start, xr: scroll X seen at every later line end.
  task automatic expect_frame(input int x0, input int xr, input int y, input int nt,
                              input bit render);
    push_ev(0, 0, -(x0 & 7), x0 * 256 + y, nt);
    for (int r = 0; r < SH; r++) begin
      int x;
      x = (r == 0) ? x0 : xr;
      push_ev(1, r, -(x & 7), x * 256 + y, nt);
      if (render)
        for (int c = -(x & 7); c < SW; c += TW) push_ev(2, r, c, x * 256 + y, nt);
    end
  endtask

  // ---------------- engine responders ----------------
  bit [2:0] en = 3'b111;
  int  rd_req = 0;
  int  rd_ack = 0;
  bit  arm_rd = 1'b0;
  int  ph[3] = '{0, 0, 0};
  int  left[3] = '{0, 0, 0};

  // Busy rises one cycle after start is seen and stays up for 3 cycles.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      bz = 3'b000;
      status_rd = 1'b0;
      for (int i = 0; i < 3; i++) begin ph[i] = 0; left[i] = 0; end
    end else begin
      status_rd = 1'b0;
      if (rd_req != rd_ack) begin status_rd = 1'b1; rd_ack = rd_req; end
      for (int i = 0; i < 3; i++) begin
        case (ph[i])
          0: if (st_now[i] && en[i]) ph[i] = 1;
          1: begin bz[i] = 1'b1; left[i] = 3; ph[i] = 2; end
          default: begin
            left[i]--;
            if (left[i] == 0) begin
              bz[i] = 1'b0;
              ph[i] = 0;
              if (i == 1 && arm_rd && pixel_row == 9'(SH - 1)) status_rd = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  logic [2:0] prev_st = 3'b000;
  logic       prev_vb = 1'b0;
  int  run[3] = '{0, 0, 0};
  int  n_ev[3] = '{0, 0, 0};
  int  gap = 0;
  bit  exp_hs = 1'b0;
  int  model_frames = 0;
  int  r0_first = 0, r0_last = 0, r0_n = 0, r1_first = 0, spr_run_last = 0;
  int  col_now;
  ev_t ev;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_st = 3'b000; prev_vb = 1'b0; gap = 0; exp_hs = 1'b0; model_frames = 0;
      for (int i = 0; i < 3; i++) run[i] = 0;
      exp_q.delete();
    end else begin
      col_now = int'($signed(pixel_col));
      for (int i = 0; i < 3; i++) begin
        if (st_now[i] && !prev_st[i]) begin
          if (i == 0) begin
            for (int k = 0; k < 3; k++) n_ev[k] = 0;
            r0_n = 0; r1_first = 999;
          end
          n_ev[i]++;
          if (i == 1 && pixel_row != 0) chk("hblank_len", gap, HB);
          if (i == 2 && pixel_row == 0) begin
            if (r0_n == 0) r0_first = col_now;
            r0_last = col_now;
            r0_n++;
          end
          if (i == 2 && pixel_row == 1 && r1_first == 999) r1_first = col_now;
          if (exp_q.size() == 0) chk("unexpected_start", i, -1);
          else begin
            ev = exp_q.pop_front();
            chk("start_engine", i, ev.eng);
            chk("start_row", int'(pixel_row), ev.row);
            chk("start_col", col_now, ev.col);
            chk("start_latch", int'(scroll_latch), ev.latch);
            chk("start_nt", int'(nt_latch), ev.nt);
          end
        end
        if (!st_now[i] && prev_st[i]) begin
          if (!en[i]) exp_hs = 1'b1;
          if (i == 1) spr_run_last = run[i];
          chk("start_width", run[i], en[i] ? 2 : STO);
        end
        run[i] = st_now[i] ? run[i] + 1 : 0;
      end
      gap = (st_now == 3'b000 && bz == 3'b000 && !vblank) ? gap + 1 : 0;
      chk("nmi", int'(nmi), int'(vblank & ppu_ctrl1[7]));
      chk("start_overlap", int'(tile_start & sprite_start), 0);
      chk("hs_timeout", int'(hs_timeout), int'(exp_hs));
      if (vblank && !prev_vb) begin
        model_frames++;
        chk("frame_queue_empty", exp_q.size(), 0);
        chk("frame_cnt", int'(frame_cnt), model_frames % 256);
        chk("vblank_row", int'(pixel_row), SH - 1);
      end
      prev_vb = vblank;
      prev_st = st_now;
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_starts"}, int'(st_now), 0);
    chk({tag, "_row"}, int'(pixel_row), 0);
    chk({tag, "_col"}, int'(pixel_col), 0);
    chk({tag, "_latch"}, int'(scroll_latch), 0);
    chk({tag, "_nt"}, int'(nt_latch), 0);
    chk({tag, "_vblank"}, int'(vblank), 0);
    chk({tag, "_nmi"}, int'(nmi), 0);
    chk({tag, "_hs"}, int'(hs_timeout), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
  endtask

  task automatic start_frame();
    @(negedge clk) vga_done = 1'b1;
    @(negedge clk) vga_done = 1'b0;
    chk("color_latency", int'(color_start), 1);
  endtask

  task automatic wait_vblank(input string nm);
    int n;
    n = 0;
    while (!vblank && n < 5000) begin @(negedge clk); n++; end
    chk({nm, "_vblank"}, int'(vblank), 1);
  endtask

  initial begin
    #12;
    chk_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Frame A: defaults, no scroll.
    expect_frame(0, 0, 0, 0, 1);
    start_frame();
    wait_vblank("A");
    chk("A_colour_reqs", n_ev[0], 1);
    chk("A_sprite_reqs", n_ev[1], SH);
    chk("A_tile_reqs", n_ev[2], SH * 32);
    chk("A_r0_first", r0_first, 0);
    chk("A_r0_last", r0_last, 248);
    chk("A_r0_count", r0_n, 32);
    chk("A_frame_cnt", int'(frame_cnt), 1);
    repeat (4) @(negedge clk);

    // Frame B: fine X 5, X changed to 0 while row 0 is rendering.
    ppu_ctrl1 = 8'h02;
    cpu_scroll_addr = 16'h0537;
    expect_frame(5, 0, 'h37, 2, 1);
    start_frame();
    begin
      int n;
      n = 0;
      while (!(pixel_row == 0 && tile_start) && n < 2000) begin @(posedge clk); #2; n++; end
      chk("B_found_row0_tile", int'(tile_start), 1);
    end
    cpu_scroll_addr = 16'h00AA;
    wait_vblank("B");
    chk("B_r0_first", r0_first, -5);
    chk("B_r0_last", r0_last, 251);
    chk("B_r0_count", r0_n, 33);
    chk("B_r1_first", r1_first, 0);
    chk("B_tile_reqs", n_ev[2], 33 + 32 * (SH - 1));
    chk("B_scroll_latch", int'(scroll_latch), 'h0037);
    chk("B_nt_latch", int'(nt_latch), 2);
    cpu_scroll_addr = 16'h0000;
    repeat (4) @(negedge clk);

    // Frame C: rendering disabled, NMI enabled, then a status read.
    ppu_ctrl1 = 8'h81;
    ppu_ctrl2 = 8'h00;
    expect_frame(0, 0, 0, 1, 0);
    start_frame();
    wait_vblank("C");
    chk("C_tile_reqs", n_ev[2], 0);
    chk("C_sprite_reqs", n_ev[1], SH);
    chk("C_nmi", int'(nmi), 1);
    chk("C_nt_latch", int'(nt_latch), 1);
    rd_req++;
    repeat (3) @(negedge clk);
    chk("C_rd_vblank", int'(vblank), 0);
    chk("C_rd_nmi", int'(nmi), 0);

    // Frame D: status read lands on the vblank-set edge.
    ppu_ctrl1 = 8'h80;
    arm_rd = 1'b1;
    expect_frame(0, 0, 0, 0, 0);
    start_frame();
    wait_vblank("D");
    repeat (2) @(negedge clk);
    chk("D_set_wins_vblank", int'(vblank), 1);
    chk("D_set_wins_nmi", int'(nmi), 1);
    arm_rd = 1'b0;
    rd_req++;
    repeat (3) @(negedge clk);
    chk("D_rd_vblank", int'(vblank), 0);

    // Frame E: sprite engine never answers.
    ppu_ctrl1 = 8'h00;
    ppu_ctrl2 = 8'h08;
    chk("E_hs_before", int'(hs_timeout), 0);
    en = 3'b101;
    expect_frame(0, 0, 0, 0, 1);
    start_frame();
    wait_vblank("E");
    chk("E_hs_after", int'(hs_timeout), 1);
    chk("E_spr_start_len", spr_run_last, STO);
    chk("E_tile_reqs", n_ev[2], SH * 32);
    chk("E_frame_cnt", int'(frame_cnt), 5);
    en = 3'b111;
    repeat (4) @(negedge clk);

    // Frame F: reset in TILE_WAIT on row 5, then a clean frame.
    ppu_ctrl2 = 8'h18;
    expect_frame(0, 0, 0, 0, 1);
    start_frame();
    begin
      int n;
      n = 0;
      while (!(pixel_row == 5 && bz[2]) && n < 3000) begin @(posedge clk); #2; n++; end
      chk("F_found_row5_wait", int'(bz[2]), 1);
    end
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_frame(0, 0, 0, 0, 1);
    start_frame();
    wait_vblank("F");
    chk("F_frame_cnt", int'(frame_cnt), 1);
    chk("F_r0_first", r0_first, 0);
    chk("F_hs", int'(hs_timeout), 0);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/ppu_frame_seq.md
# ppu_frame_seq

Parametrised PPU frame sequencer, the successor to the fixed 256x240 render controller. It walks the screen scanline by scanline and tile group by tile group, and drives the colour-load, sprite-evaluation and tile-render engines through start/busy handshakes. It latches scroll state at the correct blanking points and generates vblank/NMI. It also adds a render-disable mode, a handshake watchdog and a frame counter.

## Interface
Parameters:
- SCREEN_W, 256, visible pixels per line
- SCREEN_H, 240, visible lines per frame
- TILE_W, 8, pixels per tile-render request (power of two, ≤ 8)
- COL_W, 9, column counter width (signed two's complement)
- ROW_W, 9, row counter width
- HBLANK_CYCLES, 100, idle cycles between lines
- START_TIMEOUT, 255, max cycles waiting for busy to rise after a start

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- vga_done  in  1  VGA finished reading frame buffer; frame may start
- ppu_ctrl1  in  8  [7] NMI enable, [1:0] nametable select
- ppu_ctrl2  in  8  [3] background enable, [4] sprite enable
- cpu_scroll_addr  in  16  [15:8] scroll X, [7:0] scroll Y
- status_rd  in  1  one-cycle pulse when the CPU reads the status register
- color_start / color_busy  out / in  1 / 1  palette-load handshake
- sprite_start / sprite_busy  out / in  1 / 1  per-line sprite-evaluation handshake
- tile_start / tile_busy  out / in  1 / 1  tile-group render handshake
- pixel_row  out  ROW_W  current screen row
- pixel_col  out  COL_W  current group's first column (signed)
- scroll_latch  out  16  latched scroll {X, Y}
- nt_latch  out  2  latched nametable select
- vblank  out  1  status bit 7
- nmi  out  1  vblank & ppu_ctrl1[7] (combinational)
- hs_timeout  out  1  sticky watchdog error
- frame_cnt  out  8  completed frames, wraps at 255→0

## Operation
- States: IDLE, COLOR_REQ, COLOR_WAIT, SPR_REQ, SPR_WAIT, TILE_REQ, TILE_WAIT, HBLANK, VBLANK_WAIT.
- Handshake rule, for each engine:
  - start is registered high on entry to *_REQ.
  - In *_REQ, when busy=1: start→0, go to *_WAIT.
  - In *_WAIT, when busy=0: the operation is complete.
- Watchdog:
  - The counter clears on *_REQ entry.
  - If it reaches START_TIMEOUT with busy still 0: set hs_timeout, start→0, proceed as if the operation completed.
- IDLE & vga_done=1, all on the same edge:
  - row←0.
  - scroll_latch←cpu_scroll_addr, nt_latch←ppu_ctrl1[1:0].
  - col←−cpu_scroll_addr[10:8] (fine X, computed from the input, not the latch).
  - vblank←0.
  - go to COLOR_REQ.
- COLOR_WAIT done → SPR_REQ.
- SPR_WAIT done:
  - Sample render_en = ppu_ctrl2[3]|ppu_ctrl2[4].
  - If set → TILE_REQ; else → end-of-line.
- TILE_WAIT done:
  - If signed(col)+TILE_W ≥ SCREEN_W (computed in COL_W+1 bits) → end-of-line.
  - Else col←col+TILE_W, → TILE_REQ.
- End-of-line, not last row (row < SCREEN_H−1):
  - row←row+1.
  - scroll_latch[15:8]←cpu_scroll_addr[15:8], nt_latch[0]←ppu_ctrl1[0].
  - col←−cpu_scroll_addr[10:8].
  - → HBLANK.
- End-of-line, last row (row = SCREEN_H−1): vblank←1, frame_cnt←frame_cnt+1, → VBLANK_WAIT.
- HBLANK: wait exactly HBLANK_CYCLES cycles, then → SPR_REQ.
- VBLANK_WAIT: when vga_done=0 → IDLE.
- vblank clear: status_rd clears it. If status_rd coincides with vblank being set, set wins.
- tile_start and sprite_start are never high in the same cycle.

## Timing
- Reset values: all starts 0, row 0, col 0, latches 0, vblank 0, hs_timeout 0, frame_cnt 0, state IDLE.
- Reset mid-operation: asynchronous return to the above, effective immediately. No start may remain high.
- Handshake latencies:
  - vga_done rise → color_start high: 1 cycle.
  - busy fall → next start high: 1 cycle.
- Line period: HBLANK spans exactly HBLANK_CYCLES cycles from HBLANK entry to SPR_REQ entry.
- Tile groups per line:
  - fine X = 0: SCREEN_W/TILE_W requests.
  - fine X ≠ 0: one extra request (the first group starts at a negative column).
- hs_timeout clears only on rst.

## Test plan
- Defaults, scroll 0, engines answering busy one cycle after start for 3 cycles:
  - 32 tile requests per line, col 0…248.
  - 240 sprite requests and 1 colour request per frame.
  - vblank rises after row 239; frame_cnt=1.
- cpu_scroll_addr[15:8]=0x05:
  - first col = −5 (0x1FB); 33 requests per line, last col 251.
  - Change X to 0x00 mid-line: the next line starts at col 0.
- ppu_ctrl2=0x00: no tile_start for a whole frame; vblank still sets after 240 sprite handshakes and HBLANKs.
- ppu_ctrl1[7]=1:
  - nmi follows vblank.
  - status_rd pulse clears both.
  - status_rd on the set cycle leaves vblank=1.
- sprite_busy held 0:
  - after START_TIMEOUT cycles, sprite_start drops and hs_timeout=1.
  - The sequence continues to TILE_REQ.
- rst pulse during TILE_WAIT on row 100: all outputs at reset values the same cycle; the next vga_done starts at row 0.
